// File: rtl/hq2x_feed.sv
// hq2x_feed: turns each source pixel strobe into a group of four evenly spaced
// scaler clock-enables. The source pixel period is measured on the fly. Pixel
// and blanking information are delayed so that the scaler sees a stable pixel
// and clean line/frame resets.
// Optional build macro: HQ2X_FEED_BLANK_BLACK_EN forces pixel_out to black
// whenever the delayed pixel lies in horizontal or vertical blanking.

module hq2x_feed #(
  parameter int PIX_W = 24,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce_pix,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             hblank,
  input  logic             vblank,
  output logic             ce_in,
  output logic [PIX_W-1:0] pixel_out,
  output logic             reset_line,
  output logic             reset_frame,
  output logic [CNT_W-1:0] period,
  output logic             overrun
);

  typedef enum logic [2:0] {IDLE, EMIT1, EMIT2, EMIT3, EMIT4} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] quarter_q, quarter_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] quarterNew;
  logic             ceIn_q, ceIn_d;
  logic             overrun_q, overrun_d;
  logic             resetLine_q, resetLine_d;
  logic             resetFrame_q, resetFrame_d;
  logic [PIX_W-1:0] s1Pix_q, s1Pix_d;
  logic             s1Hblank_q, s1Hblank_d;
  logic             s1Vblank_q, s1Vblank_d;
  logic [PIX_W-1:0] s2Pix_q, s2Pix_d;
`ifdef HQ2X_FEED_BLANK_BLACK_EN
  logic             s2Blank_q, s2Blank_d;
`endif

  // Period counter stays at zero until the first strobe, so the first group after reset uses the minimum spacing.
  always_comb begin
    count_d = count_q;
    if (ce_pix) begin
      count_d = CNT_W'(1);
    end else if (count_q != '0 && count_q != '1) begin
      count_d = count_q + CNT_W'(1);
    end
    quarterNew = count_q >> 2;
    if (quarterNew == '0) begin
      quarterNew = CNT_W'(1);
    end
  end

  // Pulse-group sequencer: a strobe always restarts at pulse 1; otherwise emit the next pulse every quarter period.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    quarter_d    = quarter_q;
    period_d     = period_q;
    ceIn_d       = 1'b0;
    overrun_d    = overrun_q;
    resetLine_d  = resetLine_q;
    resetFrame_d = resetFrame_q;
    s1Pix_d      = s1Pix_q;
    s1Hblank_d   = s1Hblank_q;
    s1Vblank_d   = s1Vblank_q;
    s2Pix_d      = s2Pix_q;
`ifdef HQ2X_FEED_BLANK_BLACK_EN
    s2Blank_d    = s2Blank_q;
`endif
    if (ce_pix) begin
      if (state_q == EMIT1 || state_q == EMIT2 || state_q == EMIT3) begin
        overrun_d = 1'b1;
      end
      state_d    = EMIT1;
      ceIn_d     = 1'b1;
      quarter_d  = quarterNew;
      timer_d    = quarterNew - CNT_W'(1);
      period_d   = count_q;
      s1Pix_d    = pix_in;
      s1Hblank_d = hblank;
      s1Vblank_d = vblank;
      s2Pix_d    = s1Pix_q;
`ifdef HQ2X_FEED_BLANK_BLACK_EN
      s2Blank_d  = s1Hblank_q | s1Vblank_q;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        EMIT1, EMIT2, EMIT3: begin
          if (timer_q == '0) begin
            ceIn_d  = 1'b1;
            timer_d = quarter_q - CNT_W'(1);
            if (state_q == EMIT1) begin
              state_d = EMIT2;
            end else if (state_q == EMIT2) begin
              state_d = EMIT3;
            end else begin
              state_d      = EMIT4;
              resetLine_d  = s1Hblank_q;
              resetFrame_d = s1Vblank_q;
            end
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        EMIT4: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any group in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      period_q     <= '0;
      quarter_q    <= CNT_W'(1);
      timer_q      <= '0;
      ceIn_q       <= 1'b0;
      overrun_q    <= 1'b0;
      resetLine_q  <= 1'b1;
      resetFrame_q <= 1'b1;
      s1Pix_q      <= '0;
      s1Hblank_q   <= 1'b0;
      s1Vblank_q   <= 1'b0;
      s2Pix_q      <= '0;
`ifdef HQ2X_FEED_BLANK_BLACK_EN
      s2Blank_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      period_q     <= period_d;
      quarter_q    <= quarter_d;
      timer_q      <= timer_d;
      ceIn_q       <= ceIn_d;
      overrun_q    <= overrun_d;
      resetLine_q  <= resetLine_d;
      resetFrame_q <= resetFrame_d;
      s1Pix_q      <= s1Pix_d;
      s1Hblank_q   <= s1Hblank_d;
      s1Vblank_q   <= s1Vblank_d;
      s2Pix_q      <= s2Pix_d;
`ifdef HQ2X_FEED_BLANK_BLACK_EN
      s2Blank_q    <= s2Blank_d;
`endif
    end
  end

  assign ce_in       = ceIn_q;
  assign reset_line  = resetLine_q;
  assign reset_frame = resetFrame_q;
  assign period      = period_q;
  assign overrun     = overrun_q;
`ifdef HQ2X_FEED_BLANK_BLACK_EN
  assign pixel_out   = s2Blank_q ? '0 : s2Pix_q;
`else
  assign pixel_out   = s2Pix_q;
`endif

endmodule

// File: tb/tb_hq2x_feed.sv
// Testbench for hq2x_feed: directed pixel strobes with an expected-pulse
// scoreboard; a monitor compares every ce_in pulse against the queue.

module tb_hq2x_feed;

  logic        clk;
  logic        reset_n;
  logic        ce_pix;
  logic [23:0] pix_in;
  logic        hblank;
  logic        vblank;
  logic        ce_in;
  logic [23:0] pixel_out;
  logic        reset_line;
  logic        reset_frame;
  logic [7:0]  period;
  logic        overrun;

  typedef struct {
    int          cyc;
    logic [23:0] pix;
    logic        line;
    logic        frame;
    logic        ovr;
    logic [7:0]  per;
  } exp_t;

  typedef struct {
    int          gap;
    logic [23:0] pix;
    logic        hb;
    logic        vb;
  } vec_t;

  exp_t sb[$];
  exp_t monE;
  int   cyc = 0;
  int   totalCount = 0;
  int   passCount = 0;
  bit   monitorOn = 1'b0;

  int          mPrevGap;
  logic [23:0] mPix;
  logic        mLine;
  logic        mFrame;
  logic        mOvr;

  vec_t vecA [11] = '{
    '{8, 24'h111111, 1'b1, 1'b1},
    '{8, 24'h222222, 1'b1, 1'b0},
    '{8, 24'hA5A5A5, 1'b0, 1'b0},
    '{8, 24'h333333, 1'b0, 1'b0},
    '{5, 24'h444444, 1'b1, 1'b0},
    '{4, 24'h555555, 1'b0, 1'b0},
    '{4, 24'h666666, 1'b0, 1'b0},
    '{4, 24'h777777, 1'b0, 1'b0},
    '{8, 24'hFFFFFF, 1'b0, 1'b1},
    '{8, 24'h888888, 1'b0, 1'b0},
    '{20, 24'h999999, 1'b0, 1'b0}
  };

  vec_t vecB [3] = '{
    '{8, 24'hABCDEF, 1'b0, 1'b0},
    '{8, 24'h123456, 1'b0, 1'b0},
    '{12, 24'hFEDCBA, 1'b0, 1'b0}
  };

  hq2x_feed dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .ce_pix      (ce_pix),
    .pix_in      (pix_in),
    .hblank      (hblank),
    .vblank      (vblank),
    .ce_in       (ce_in),
    .pixel_out   (pixel_out),
    .reset_line  (reset_line),
    .reset_frame (reset_frame),
    .period      (period),
    .overrun     (overrun)
  );

  // Free-running clock and cycle counter (cyc = number of rising edges so far).
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    totalCount++;
    if (act === expv) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic resetModel();
    mPrevGap = 0;
    mPix     = 24'h0;
    mLine    = 1'b1;
    mFrame   = 1'b1;
    mOvr     = 1'b0;
  endtask

  // Issue one source pixel at the current falling edge and hold the gap; the
  // expected pulses of its group are queued before the strobe is driven.
  task automatic applyStimulus(input int gap, input logic [23:0] pix, input logic hb, input logic vb);
    int   per;
    int   q;
    int   nPulse;
    exp_t e;
    per = (mPrevGap > 255) ? 255 : mPrevGap;
    q   = per / 4;
    if (q == 0) q = 1;
    nPulse = 0;
    for (int k = 0; k < 4; k++) begin
      if (k * q < gap) begin
        if (k == 3) begin
          mLine  = hb;
          mFrame = vb;
        end
        e.cyc   = cyc + 1 + k * q;
        e.pix   = mPix;
        e.line  = mLine;
        e.frame = mFrame;
        e.ovr   = mOvr;
        e.per   = 8'(per);
        sb.push_back(e);
        nPulse++;
      end
    end
    if (nPulse < 4) mOvr = 1'b1;
`ifdef HQ2X_FEED_BLANK_BLACK_EN
    mPix = (hb | vb) ? 24'h0 : pix;
`else
    mPix = pix;
`endif
    mPrevGap = gap;
    ce_pix = 1'b1;
    pix_in = pix;
    hblank = hb;
    vblank = vb;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      ce_pix = 1'b0;
    end
  endtask

  // Monitor: every ce_in pulse must match the oldest queued expectation, and
  // a queued pulse whose cycle has passed counts as missed.
  always @(negedge clk) begin
    if (monitorOn && reset_n === 1'b1) begin
      if (ce_in === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("ce_in unexpected", {31'b0, ce_in}, 32'd0);
        end else begin
          monE = sb.pop_front();
          checkOutput("pulse cycle", 32'(cyc), 32'(monE.cyc));
          checkOutput("pixel_out", {8'h0, pixel_out}, {8'h0, monE.pix});
          checkOutput("reset_line", {31'b0, reset_line}, {31'b0, monE.line});
          checkOutput("reset_frame", {31'b0, reset_frame}, {31'b0, monE.frame});
          checkOutput("overrun", {31'b0, overrun}, {31'b0, monE.ovr});
          checkOutput("period", {24'h0, period}, {24'h0, monE.per});
        end
      end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
        monE = sb.pop_front();
        checkOutput("missed ce_in pulse", 32'(cyc), 32'(monE.cyc));
      end
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " ce_in"}, {31'b0, ce_in}, 32'd0);
    checkOutput({tag, " pixel_out"}, {8'h0, pixel_out}, 32'd0);
    checkOutput({tag, " period"}, {24'h0, period}, 32'd0);
    checkOutput({tag, " overrun"}, {31'b0, overrun}, 32'd0);
    checkOutput({tag, " reset_line"}, {31'b0, reset_line}, 32'd1);
    checkOutput({tag, " reset_frame"}, {31'b0, reset_frame}, 32'd1);
  endtask

  initial begin
    int seen;
    reset_n = 1'b0;
    ce_pix  = 1'b0;
    pix_in  = 24'h0;
    hblank  = 1'b0;
    vblank  = 1'b0;
    repeat (2) @(negedge clk);
    checkResetValues("power-on reset");
    reset_n = 1'b1;
    @(negedge clk);
    resetModel();
    monitorOn = 1'b1;

    foreach (vecA[i]) applyStimulus(vecA[i].gap, vecA[i].pix, vecA[i].hb, vecA[i].vb);
    checkOutput("scoreboard drained before reset", 32'(sb.size()), 32'd0);

    monitorOn = 1'b0;
    seen = 0;
    ce_pix = 1'b1;
    for (int i = 0; i < 40 && seen < 2; i++) begin
      @(negedge clk);
      ce_pix = 1'b0;
      if (ce_in === 1'b1) seen++;
    end
    checkOutput("reached pulse 2 before reset", 32'(seen), 32'd2);
    #2 reset_n = 1'b0;
    #1 checkResetValues("mid-group reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    resetModel();
    monitorOn = 1'b1;

    foreach (vecB[i]) applyStimulus(vecB[i].gap, vecB[i].pix, vecB[i].hb, vecB[i].vb);
    @(negedge clk);
    checkOutput("scoreboard drained at end", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
